alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_mul_unit.sv | 67 ++++++
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions
// and FSM state encodings. The MUL state exists only when ALU_SEQ_MUL_EN
// is defined.
package alu_pkg;

    localparam logic [7:0] OP_AND   = 8'h01;
    localparam logic [7:0] OP_OR    = 8'h02;
    localparam logic [7:0] OP_XOR   = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_ADDU  = 8'h06;
    localparam logic [7:0] OP_ADDC  = 8'h07;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_MUL   = 8'h0E;
    localparam logic [7:0] OP_LSH   = 8'h84;
    localparam logic [7:0] OP_RSH   = 8'h8C;
    localparam logic [7:0] OP_ANDI  = 8'h10;
    localparam logic [7:0] OP_ORI   = 8'h20;
    localparam logic [7:0] OP_XORI  = 8'h30;
    localparam logic [7:0] OP_ADDI  = 8'h50;
    localparam logic [7:0] OP_ADDUI = 8'h60;

    // Flag register bit positions
    localparam int FLG_C = 0;
    localparam int FLG_L = 1;
    localparam int FLG_F = 2;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_DONE = 2'd2
    } alu_state_e;

    // Immediate forms take the Immediate operand in place of SRC
    function automatic logic is_imm_op(input logic [7:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) ||
               (op == OP_ADDI) || (op == OP_ADDUI);
    endfunction

endpackage

// File: rtl/alu_mul_unit.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// The first partial product is folded in on the start edge, so done is
// high after WIDTH-1 further cycles and product is final while done is high.
// Built only when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_unit
#(
    parameter int WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic                 busy;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand_ext;
    logic [2*WIDTH-1:0]   mcand_sh;
    logic [WIDTH-1:0]     mplier_sh;
    logic [2*WIDTH-1:0]   acc;

    assign mcand_ext = {{WIDTH{1'b0}}, mcand};

    // Iteration counter: counts partial products already accumulated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(1);
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shift-add datapath: add the shifted multiplicand when the multiplier LSB is set
    always_ff @(posedge clk) begin
        if (start) begin
            acc       <= mplier[0] ? mcand_ext : '0;
            mcand_sh  <= mcand_ext << 1;
            mplier_sh <= mplier >> 1;
        end else if (busy && (cnt != LAST)) begin
            acc       <= acc + (mplier_sh[0] ? mcand_sh : '0);
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
        end
    end

    assign done    = busy && (cnt == LAST);
    assign product = acc;

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle
// ops land in DONE one edge after acceptance; MUL iterates in the
// alu_mul_unit sub-module when ALU_SEQ_MUL_EN is defined, otherwise opcode
// 0x0E behaves as an undefined opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter logic [4:0] FLAGS_RST = 5'b00000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        Opcode,
    input  logic [WIDTH-1:0]  SRC,
    input  logic [WIDTH-1:0]  DST,
    input  logic [WIDTH-1:0]  Immediate,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  C,
    output logic [4:0]        Flags
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e               state;
    logic                     accept;
    logic                     imm_op;
    logic                     addc_cin;
    logic [WIDTH-1:0]         opnd;
    logic signed [WIDTH-1:0]  dst_s;
    logic signed [WIDTH-1:0]  src_s;
    logic signed [WIDTH-1:0]  opnd_s;
    logic [WIDTH:0]           sum;
    logic [WIDTH:0]           diff;
    logic [SHW-1:0]           shamt;
    logic [WIDTH:0]           lsh_ext;
    logic [WIDTH:0]           rsh_ext;
    logic [WIDTH-1:0]         alu_res;
    logic [4:0]               alu_flags;

    // Z and N follow the result
    function automatic logic [4:0] set_zn(input logic [4:0] f, input logic [WIDTH-1:0] r);
        logic [4:0] o;
        o        = f;
        o[FLG_Z] = (r == '0);
        o[FLG_N] = r[WIDTH-1];
        return o;
    endfunction

    // Signed overflow of a + b: operands agree in sign, result disagrees
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    // Signed overflow of a - b: operands differ in sign, result takes b's sign
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign imm_op   = is_imm_op(Opcode);
    assign opnd     = imm_op ? Immediate : SRC;
    assign addc_cin = (Opcode == OP_ADDC) && c_in;
    assign dst_s    = DST;
    assign src_s    = SRC;
    assign opnd_s   = opnd;

    // One extra bit on add/sub holds carry-out / borrow
    assign sum      = {1'b0, DST} + {1'b0, opnd} + {{WIDTH{1'b0}}, addc_cin};
    assign diff     = {1'b0, DST} - {1'b0, opnd};

    // Extended shifts keep the last bit shifted out next to the result;
    // a zero shift leaves the guard bit at 0
    assign shamt    = SRC[SHW-1:0];
    assign lsh_ext  = {1'b0, DST} << shamt;
    assign rsh_ext  = {DST, 1'b0} >> shamt;

    // Single-cycle result and next-flag computation from the live operands
    always_comb begin
        alu_res   = DST;
        alu_flags = Flags;
        case (Opcode)
            OP_AND, OP_ANDI: begin
                alu_res   = DST & opnd;
                alu_flags = set_zn(Flags, alu_res);
            end
            OP_OR, OP_ORI: begin
                alu_res   = DST | opnd;
                alu_flags = set_zn(Flags, alu_res);
            end
            OP_XOR, OP_XORI: begin
                alu_res   = DST ^ opnd;
                alu_flags = set_zn(Flags, alu_res);
            end
            OP_ADD, OP_ADDU, OP_ADDC, OP_ADDI, OP_ADDUI: begin
                alu_res          = sum[WIDTH-1:0];
                alu_flags        = set_zn(Flags, alu_res);
                alu_flags[FLG_C] = sum[WIDTH];
                alu_flags[FLG_F] = add_ovf(dst_s, opnd_s, sum[WIDTH-1:0]);
            end
            OP_SUB: begin
                alu_res          = diff[WIDTH-1:0];
                alu_flags        = set_zn(Flags, alu_res);
                alu_flags[FLG_C] = diff[WIDTH];
                alu_flags[FLG_F] = sub_ovf(dst_s, opnd_s, diff[WIDTH-1:0]);
            end
            OP_CMP: begin
                alu_res          = DST;
                alu_flags[FLG_Z] = (SRC == DST);
                alu_flags[FLG_N] = (src_s > dst_s);
                alu_flags[FLG_L] = (SRC > DST);
            end
            OP_LSH: begin
                alu_res          = lsh_ext[WIDTH-1:0];
                alu_flags        = set_zn(Flags, alu_res);
                alu_flags[FLG_C] = lsh_ext[WIDTH];
            end
            OP_RSH: begin
                alu_res          = rsh_ext[WIDTH:1];
                alu_flags        = set_zn(Flags, alu_res);
                alu_flags[FLG_C] = rsh_ext[0];
            end
            default: begin
                alu_res   = DST;
                alu_flags = Flags;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic                  is_mul_op;
    logic                  mul_start;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;
    logic [4:0]            mul_flags;

    assign is_mul_op = (Opcode == OP_MUL);
    assign mul_start = accept && is_mul_op;

    alu_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .mcand   (DST),
        .mplier  (SRC),
        .done    (mul_done),
        .product (mul_product)
    );

    // MUL flags: C flags a non-zero high half, Z/N from the low half
    always_comb begin
        mul_flags        = set_zn(Flags, mul_product[WIDTH-1:0]);
        mul_flags[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
    end
`endif

    // Handshake FSM with registered result, flags and out_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            C         <= '0;
            Flags     <= FLAGS_RST;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (is_mul_op) begin
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            C         <= alu_res;
                            Flags     <= alu_flags;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        C         <= mul_product[WIDTH-1:0];
                        Flags     <= mul_flags;
                    end
                end
`endif
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized
// operations against an arithmetic reference model. MUL expectations
// depend on whether ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    localparam int         W       = 16;
    localparam logic [4:0] TB_FRST = 5'b10110;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [7:0] T_AND = 8'h01, T_OR = 8'h02, T_XOR = 8'h03;
    localparam logic [7:0] T_ADD = 8'h05, T_ADDU = 8'h06, T_ADDC = 8'h07;
    localparam logic [7:0] T_SUB = 8'h09, T_CMP = 8'h0B, T_MUL = 8'h0E;
    localparam logic [7:0] T_LSH = 8'h84, T_RSH = 8'h8C;
    localparam logic [7:0] T_ANDI = 8'h10, T_ORI = 8'h20, T_XORI = 8'h30;
    localparam logic [7:0] T_ADDI = 8'h50, T_ADDUI = 8'h60;
    localparam logic [7:0] OP_TBL [16] = '{T_AND, T_OR, T_XOR, T_ADD, T_ADDU, T_ADDC,
                                           T_SUB, T_CMP, T_MUL, T_LSH, T_RSH, T_ANDI,
                                           T_ORI, T_XORI, T_ADDI, T_ADDUI};

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    Opcode;
    logic [W-1:0]  SRC, DST, Immediate;
    logic          c_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  C;
    logic [4:0]    Flags;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [4:0]    mflags;

    alu_seq #(.WIDTH(W), .FLAGS_RST(TB_FRST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Opcode    (Opcode),
        .SRC       (SRC),
        .DST       (DST),
        .Immediate (Immediate),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .Flags     (Flags)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values
    function automatic void model(input logic [7:0] op, input logic [W-1:0] s, d, imm,
                                  input logic ci, input logic [4:0] fin,
                                  output logic [W-1:0] r, output logic [4:0] fo);
        longint m, half, ud, us, sd, ss, t, sgn;
        int amt;
        bit upd;
        m    = longint'(1) << W;
        half = m / 2;
        ud   = longint'(d);
        us   = (op inside {T_ANDI, T_ORI, T_XORI, T_ADDI, T_ADDUI}) ? longint'(imm) : longint'(s);
        sd   = (ud >= half) ? ud - m : ud;
        ss   = (us >= half) ? us - m : us;
        amt  = int'(longint'(s) % W);
        fo   = fin;
        t    = ud;
        upd  = 1'b1;
        case (op)
            T_AND, T_ANDI: t = ud & us;
            T_OR,  T_ORI:  t = ud | us;
            T_XOR, T_XORI: t = ud ^ us;
            T_ADD, T_ADDU, T_ADDC, T_ADDI, T_ADDUI: begin
                t     = ud + us + ((op == T_ADDC) ? longint'(ci) : 0);
                sgn   = sd + ss + ((op == T_ADDC) ? longint'(ci) : 0);
                fo[0] = (t >= m);
                fo[2] = (sgn >= half) || (sgn < -half);
                t     = t % m;
            end
            T_SUB: begin
                t     = ud - us;
                sgn   = sd - ss;
                fo[0] = (ud < us);
                fo[2] = (sgn >= half) || (sgn < -half);
                if (t < 0) t = t + m;
            end
            T_CMP: begin
                fo[4] = (us == ud);
                fo[3] = (ss > sd);
                fo[1] = (us > ud);
                upd   = 1'b0;
            end
            T_LSH: begin
                t     = (ud * (longint'(1) << amt)) % m;
                fo[0] = (amt == 0) ? 1'b0 : (((ud >> (W - amt)) & 1) == 1);
            end
            T_RSH: begin
                t     = ud / (longint'(1) << amt);
                fo[0] = (amt == 0) ? 1'b0 : (((ud >> (amt - 1)) & 1) == 1);
            end
            T_MUL: begin
                if (MUL_EN) begin
                    t     = ud * us;
                    fo[0] = (t >= m);
                    t     = t % m;
                end else begin
                    upd = 1'b0;
                end
            end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            fo[4] = (t == 0);
            fo[3] = (t >= half);
        end
        r = t[W-1:0];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one operation, check latency/result/flags, then optionally stall the consumer
    task automatic run_op(input logic [7:0] op, input logic [W-1:0] s, d, imm,
                          input logic ci, input int hold);
        logic [W-1:0] er;
        logic [4:0]   ef;
        int           exp_lat;
        int           k;
        bit           got;
        model(op, s, d, imm, ci, mflags, er, ef);
        exp_lat = (MUL_EN && op == T_MUL) ? W + 1 : 1;
        @(negedge clk);
        chk_val("in_ready_before_accept", in_ready, 1);
        Opcode = op; SRC = s; DST = d; Immediate = imm; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        k = 1; got = 1'b0;
        while (k <= W + 4 && !got) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                chk_val("in_ready_while_busy", in_ready, 0);
                in_valid = 1'b1; Opcode = T_ADD; SRC = W'($urandom); DST = W'($urandom);
                @(posedge clk); #1;
                in_valid = 1'b0;
                k++;
            end
        end
        chk_val($sformatf("latency op=%0h", op), got ? k : 0, exp_lat);
        chk_val($sformatf("result op=%0h s=%0h d=%0h i=%0h", op, s, d, imm), C, er);
        chk_val($sformatf("flags op=%0h s=%0h d=%0h i=%0h", op, s, d, imm), Flags, ef);
        mflags = ef;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk_val("hold_out_valid", out_valid, 1);
            chk_val("hold_in_ready", in_ready, 0);
            chk_val("hold_result", C, er);
            chk_val("hold_flags", Flags, ef);
        end
        out_ready = 1'b1;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(posedge clk);
        #1;
        chk_val("idle_out_valid", out_valid, 0);
        chk_val("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; Opcode = '0;
        SRC = '0; DST = '0; Immediate = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_out_valid", out_valid, 0);
        chk_val("reset_C", C, 0);
        chk_val("reset_flags", Flags, TB_FRST);
        chk_val("reset_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_val("post_reset_in_ready", in_ready, 1);
        chk_val("post_reset_out_valid", out_valid, 0);
        mflags = TB_FRST;

        // Signed overflow on ADD
        run_op(T_ADD, 16'h7FFF, 16'h7FFF, 16'h0, 1'b0, 0);
        chk_val("add_C", C, 16'hFFFE);
        chk_val("add_F", Flags[2], 1);
        chk_val("add_N", Flags[3], 1);
        chk_val("add_Z", Flags[4], 0);
        // Carry-out wrap to zero
        run_op(T_ADDU, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 0);
        chk_val("addu_C", C, 16'h0000);
        chk_val("addu_carry", Flags[0], 1);
        chk_val("addu_Z", Flags[4], 1);
        // CMP semantics
        run_op(T_CMP, 16'h0001, 16'h0000, 16'h0, 1'b0, 0);
        chk_val("cmp_N", Flags[3], 1);
        chk_val("cmp_L", Flags[1], 1);
        chk_val("cmp_Z", Flags[4], 0);
        chk_val("cmp_C", C, 16'h0000);
        run_op(T_CMP, 16'h0003, 16'h0003, 16'h0, 1'b0, 0);
        chk_val("cmp_eq_Z", Flags[4], 1);
        // MUL with high-half overflow
        run_op(T_MUL, 16'h0100, 16'h0100, 16'h0, 1'b0, 0);
`ifdef ALU_SEQ_MUL_EN
        chk_val("mul_C", C, 16'h0000);
        chk_val("mul_carry", Flags[0], 1);
        chk_val("mul_Z", Flags[4], 1);
`else
        chk_val("mul_undef_C", C, 16'h0100);
`endif
        // Shift boundaries, borrow, carry-in, undefined opcode
        run_op(T_LSH, 16'h0000, 16'h8001, 16'h0, 1'b0, 0);
        run_op(T_LSH, 16'h0001, 16'h8001, 16'h0, 1'b0, 0);
        run_op(T_LSH, 16'h001F, 16'h0003, 16'h0, 1'b0, 0);
        run_op(T_RSH, 16'h000F, 16'h8000, 16'h0, 1'b0, 0);
        run_op(T_RSH, 16'h0001, 16'h0001, 16'h0, 1'b0, 0);
        run_op(T_SUB, 16'h0001, 16'h0000, 16'h0, 1'b0, 0);
        run_op(T_SUB, 16'h0001, 16'h8000, 16'h0, 1'b0, 0);
        run_op(T_ADDC, 16'h0000, 16'hFFFF, 16'h0, 1'b1, 0);
        run_op(T_ADDI, 16'hFFFF, 16'h0002, 16'h7FFF, 1'b1, 0);
        run_op(8'hFF, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 0);

        // Consumer stall for 5 cycles, then back-to-back accept on release
        run_op(T_XOR, 16'hA5A5, 16'h0FF0, 16'h0, 1'b0, 5);
        run_op(T_OR, 16'h00F0, 16'h0F00, 16'h0, 1'b0, 0);
        idle_gap(2);

        // Reset in the middle of a MUL (or a stalled result without MUL)
        @(negedge clk);
        Opcode = T_MUL; SRC = 16'h1234; DST = 16'h00FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_val("midrst_out_valid", out_valid, 0);
        chk_val("midrst_flags", Flags, TB_FRST);
        chk_val("midrst_C", C, 0);
        chk_val("midrst_in_ready", in_ready, 1);
        mflags = TB_FRST;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        run_op(T_MUL, 16'h0123, 16'h0456, 16'h0, 1'b0, 0);
        run_op(T_ADD, 16'h0001, 16'h0002, 16'h0, 1'b0, 0);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [7:0] op;
            int         hold;
            if ($urandom_range(0, 9) == 0) op = 8'($urandom);
            else                           op = OP_TBL[$urandom_range(0, 15)];
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 5) == 0) idle_gap(int'($urandom_range(1, 3)));
            run_op(op, pick(), pick(), pick(), 1'($urandom), hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
